// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int X0_IDX    = 0;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: NRD read ports, one write port
// and one scoreboard claim port.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NRD  = 2,
  parameter int AW   = 5
);

  logic [NRD-1:0]           rd_en;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     claim_en;
  logic [AW-1:0]            claim_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register marks an outstanding producer.
// Busy for each query index is taken from the next-state vector so that a
// claim or write in the current cycle is already reflected.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [NRD-1:0][AW-1:0] q_addr,
  output logic [NRD-1:0]         q_busy_next
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;

  // Release on writeback, then claim; a same-cycle claim belongs to a newer
  // producer so it wins. x0 can never be pending.
  always_comb begin
    pend_next = pend;
    if (wr_en) pend_next[wr_addr] = 1'b0;
    if (claim_en) pend_next[claim_addr] = 1'b1;
    pend_next[X0_IDX] = 1'b0;
  end

  // Pending vector register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  // Per-query lookup; index 0 reads the constant-zero bit.
  always_comb begin
    q_busy_next = '0;
    for (int q = 0; q < NRD; q++) q_busy_next[q] = pend_next[q_addr[q]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Flip-flop register file with NRD registered read ports, write-first
// forwarding, hardwired-zero x0 and an async clear of all state.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  logic [XLEN-1:0] mem [NREGS];
  logic [NRD-1:0]  busy_next;
  logic [XLEN-1:0] rd_word [NRD];
  logic            wr_live;

  assign wr_live = bus.wr_en && (bus.wr_addr != AW'(X0_IDX));

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .claim_en    (bus.claim_en),
    .claim_addr  (bus.claim_addr),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .q_addr      (bus.rd_addr),
    .q_busy_next (busy_next)
  );

  // Storage; entry 0 is only ever reset, so it folds to a constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (wr_live) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read mux per port with forwarding of the write landing this cycle.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_word[p] = mem[bus.rd_addr[p]];
      if (bus.rd_addr[p] == AW'(X0_IDX)) rd_word[p] = '0;
      else if (bus.wr_en && (bus.wr_addr == bus.rd_addr[p])) rd_word[p] = bus.wr_data;
    end
  end

  // Output registers; a disabled port holds both data and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
      bus.rd_busy <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (bus.rd_en[p]) begin
          bus.rd_data[p] <= rd_word[p];
          bus.rd_busy[p] <= busy_next[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp at NRD=3, NREGS=16, XLEN=64: directed scenarios with
// literal expectations, then a random stream, all checked every cycle against
// an array-based model of the register file.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model state
  logic [XLEN-1:0] m_mem [NREGS];
  logic [NREGS-1:0] m_pend;
  logic [XLEN-1:0] exp_data [NRD];
  logic            exp_busy [NRD];

  // Literal expectations for the check at the end of the current cycle
  logic            chk_on = 1'b0;
  logic [NRD-1:0]  lit_on = '0;
  logic [XLEN-1:0] lit_data [NRD];
  logic            lit_busy [NRD];
  string           lit_name = "";

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: apply the edge's write and claim to the architectural state, then
  // each enabled read sees the resulting state (write-first semantics).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
      m_pend = '0;
      for (int p = 0; p < NRD; p++) begin
        exp_data[p] = '0;
        exp_busy[p] = 1'b0;
      end
    end else begin
      if (bus.wr_en && bus.wr_addr != 0) begin
        m_mem[bus.wr_addr]  = bus.wr_data;
        m_pend[bus.wr_addr] = 1'b0;
      end
      if (bus.claim_en && bus.claim_addr != 0) m_pend[bus.claim_addr] = 1'b1;
      for (int p = 0; p < NRD; p++) begin
        if (bus.rd_en[p]) begin
          exp_data[p] = (bus.rd_addr[p] == 0) ? '0 : m_mem[bus.rd_addr[p]];
          exp_busy[p] = (bus.rd_addr[p] == 0) ? 1'b0 : m_pend[bus.rd_addr[p]];
        end
      end
    end
  end

  // Compare DUT to model every cycle; literal expectations pin both.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < NRD; p++) begin
        n_cmp++;
        if (bus.rd_data[p] !== exp_data[p] || bus.rd_busy[p] !== exp_busy[p]) begin
          n_fail++;
          $display("FAIL model port%0d t=%0t: dut data=%h busy=%b, model data=%h busy=%b",
                   p, $time, bus.rd_data[p], bus.rd_busy[p], exp_data[p], exp_busy[p]);
        end
        if (lit_on[p]) begin
          n_cmp++;
          if (bus.rd_data[p] !== lit_data[p] || bus.rd_busy[p] !== lit_busy[p]) begin
            n_fail++;
            $display("FAIL %s port%0d: dut data=%h busy=%b, expected data=%h busy=%b",
                     lit_name, p, bus.rd_data[p], bus.rd_busy[p], lit_data[p], lit_busy[p]);
          end
          n_cmp++;
          if (exp_data[p] !== lit_data[p] || exp_busy[p] !== lit_busy[p]) begin
            n_fail++;
            $display("FAIL %s model port%0d: model data=%h busy=%b, expected data=%h busy=%b",
                     lit_name, p, exp_data[p], exp_busy[p], lit_data[p], lit_busy[p]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Start a new cycle of stimulus just after the checking edge.
  task automatic next();
    @(negedge clk);
    #1;
    bus.rd_en    = '0;
    bus.wr_en    = 1'b0;
    bus.claim_en = 1'b0;
    lit_on       = '0;
  endtask

  task automatic rd(input int p, input int a);
    bus.rd_en[p]   = 1'b1;
    bus.rd_addr[p] = AW'(a);
  endtask

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic claim(input int a);
    bus.claim_en   = 1'b1;
    bus.claim_addr = AW'(a);
  endtask

  task automatic expect_lit(input string name, input int p,
                            input logic [XLEN-1:0] d, input logic b);
    lit_name    = name;
    lit_on[p]   = 1'b1;
    lit_data[p] = d;
    lit_busy[p] = b;
  endtask

  function automatic logic [AW-1:0] pick(input bit narrow);
    return narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS-1));
  endfunction

  initial begin
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.claim_en   = 1'b0;
    bus.claim_addr = '0;

    #1 rst = 1'b1;
    chk_on = 1'b1;
    for (int p = 0; p < NRD; p++) expect_lit("reset_state", p, '0, 1'b0);
    next();
    rst = 1'b0;

    // x0 protection
    wr(0, 64'hFFFF_FFFF); claim(0); rd(0, 0);
    expect_lit("x0_same_cycle", 0, '0, 1'b0);
    next();
    for (int p = 0; p < NRD; p++) begin
      rd(p, 0);
      expect_lit("x0_after", p, '0, 1'b0);
    end

    // Forwarding, multiple ports on one index
    next();
    wr(7, 64'h1234_5678); rd(0, 7); rd(1, 7);
    expect_lit("fwd", 0, 64'h1234_5678, 1'b0);
    expect_lit("fwd", 1, 64'h1234_5678, 1'b0);
    next();
    for (int p = 0; p < NRD; p++) begin
      rd(p, 7);
      expect_lit("fwd_reread", p, 64'h1234_5678, 1'b0);
    end

    // Read hold
    next();
    wr(3, 64'hA5A5_A5A5);
    next();
    rd(0, 3);
    expect_lit("hold_read", 0, 64'hA5A5_A5A5, 1'b0);
    next();
    wr(3, 64'h1);
    expect_lit("hold_during_write", 0, 64'hA5A5_A5A5, 1'b0);
    next();
    expect_lit("hold_idle", 0, 64'hA5A5_A5A5, 1'b0);
    next();
    rd(0, 3);
    expect_lit("hold_reread", 0, 64'h1, 1'b0);

    // Scoreboard
    next();
    claim(9);
    next();
    rd(1, 9);
    expect_lit("sb_claimed", 1, '0, 1'b1);
    next();
    claim(9); wr(9, 64'hCAFE); rd(1, 9);
    expect_lit("sb_claim_and_write", 1, 64'hCAFE, 1'b1);
    next();
    wr(9, 64'hBEEF); rd(1, 9);
    expect_lit("sb_write_releases", 1, 64'hBEEF, 1'b0);
    next();
    claim(10); rd(2, 10);
    expect_lit("sb_claim_same_cycle", 2, '0, 1'b1);
    next();
    claim(10);
    next();
    rd(2, 10);
    expect_lit("sb_reclaim", 2, '0, 1'b1);

    // Reset in the middle of a cycle
    next();
    wr(5, 64'hDEAD_BEEF); claim(5);
    next();
    for (int p = 0; p < NRD; p++) begin
      rd(p, 5);
      expect_lit("pre_reset", p, 64'hDEAD_BEEF, 1'b1);
    end
    next();
    for (int p = 0; p < NRD; p++) expect_lit("async_reset", p, '0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    next();
    next();
    rst = 1'b0;
    rd(0, 10); rd(1, 5); rd(2, 5);
    expect_lit("after_reset_x10", 0, '0, 1'b0);
    expect_lit("after_reset_x5", 1, '0, 1'b0);
    expect_lit("after_reset_x5", 2, '0, 1'b0);

    // Random stream, half of the cycles confined to x0..x3 to force collisions
    for (int c = 0; c < 1500; c++) begin
      bit narrow;
      next();
      narrow = bit'($urandom_range(0, 1));
      for (int p = 0; p < NRD; p++) begin
        bus.rd_en[p]   = 1'($urandom_range(0, 1));
        bus.rd_addr[p] = pick(narrow);
      end
      bus.wr_en      = 1'($urandom_range(0, 1));
      bus.wr_addr    = pick(narrow);
      bus.wr_data    = {$urandom, $urandom};
      bus.claim_en   = ($urandom_range(0, 2) == 0);
      bus.claim_addr = pick(narrow);
      if (c == 700) begin
        @(posedge clk);
        #3 rst = 1'b1;
        next();
        rst = 1'b0;
      end
    end

    next();
    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
